vga_sync_pixel_pipe: RTL and testbench

Downstream stage of the pixel-position iterator. Consumes the free-running xCounter/yCounter pair and produces registered VGA_HS/VGA_VS/VGA_BLANK/VGA_SYNC signals. Issues framebuffer read addresses for the visible region, with optional downscaling, and delays the sync and blank signals to align with the framebuffer's fixed read latency. Expands packed pixel colour into 10-bit-per-channel DAC outputs, forced to black outside the visible area.

---
 rtl/vga_sync_pixel_pipe_if.sv | 23 ++
 rtl/vga_sync_pixel_pipe.sv | 139 +++++++++++++
 tb/tb_vga_sync_pixel_pipe.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_pixel_pipe_if.sv
// Framebuffer read port between the VGA pixel pipe (master) and the pixel memory (slave).
// fb_rd_en is a valid-only strobe: the memory has no ready and accepts every cycle.
// pixel_data returns exactly MEM_LATENCY cycles after the fb_addr it belongs to.
interface vga_sync_pixel_pipe_if #(
  parameter int ADDR_WIDTH         = 17,
  parameter int COLOR_CHANNEL_BITS = 3
);
  logic [ADDR_WIDTH-1:0]           fb_addr;
  logic                            fb_rd_en;
  logic [3*COLOR_CHANNEL_BITS-1:0] pixel_data;

  modport master (
    output fb_addr,
    output fb_rd_en,
    input  pixel_data
  );

  modport slave (
    input  fb_addr,
    input  fb_rd_en,
    output pixel_data
  );
endinterface

// File: rtl/vga_sync_pixel_pipe.sv
// VGA sync/blank generation and framebuffer read path, with the sync/blank
// signals delayed to match the framebuffer read latency before the DAC register.
module vga_sync_pixel_pipe #(
  parameter int C_VERT_NUM_PIXELS  = 480,
  parameter int C_VERT_SYNC_START  = 493,
  parameter int C_VERT_SYNC_END    = 494,
  parameter int C_HORZ_NUM_PIXELS  = 640,
  parameter int C_HORZ_SYNC_START  = 659,
  parameter int C_HORZ_SYNC_END    = 754,
  parameter int RES_SHIFT          = 1,
  parameter int ADDR_WIDTH         = 17,
  parameter int MEM_LATENCY        = 1,
  parameter int COLOR_CHANNEL_BITS = 3
) (
  input  logic                 vga_clock,
  input  logic                 resetn,
  input  logic [9:0]           xCounter,
  input  logic [9:0]           yCounter,
  vga_sync_pixel_pipe_if.master fb,
  output logic [9:0]           VGA_R,
  output logic [9:0]           VGA_G,
  output logic [9:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK,
  output logic                 VGA_SYNC,
  output logic                 frame_start
);

  localparam int CB   = COLOR_CHANNEL_BITS;
  localparam int REPS = (10 + CB - 1) / CB;

  localparam logic [9:0]  H_VIS      = 10'(C_HORZ_NUM_PIXELS);
  localparam logic [9:0]  V_VIS      = 10'(C_VERT_NUM_PIXELS);
  localparam logic [9:0]  H_SYNC_S   = 10'(C_HORZ_SYNC_START);
  localparam logic [9:0]  H_SYNC_E   = 10'(C_HORZ_SYNC_END);
  localparam logic [9:0]  V_SYNC_S   = 10'(C_VERT_SYNC_START);
  localparam logic [9:0]  V_SYNC_E   = 10'(C_VERT_SYNC_END);
  localparam logic [31:0] FB_WIDTH   = 32'(C_HORZ_NUM_PIXELS >> RES_SHIFT);

  // Control bits that travel alongside the pixel through the pipe.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic visible;
    logic frame;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, visible: 1'b0, frame: 1'b0};

  ctl_t        ctl_next;
  ctl_t        ctl_s1;
  ctl_t        ctl_dly [MEM_LATENCY];
  ctl_t        ctl_mem;
  logic [31:0] addr_full;

  logic [CB-1:0] pix_r;
  logic [CB-1:0] pix_g;
  logic [CB-1:0] pix_b;

  // Repeat the channel MSB-first and keep the top 10 bits.
  function automatic logic [9:0] expand(input logic [CB-1:0] c);
    logic [REPS*CB-1:0] rep;
    rep = {REPS{c}};
    return rep[REPS*CB-1 -: 10];
  endfunction

  always_comb begin
    ctl_next         = CTL_IDLE;
    ctl_next.visible = (xCounter < H_VIS) && (yCounter < V_VIS);
    ctl_next.hs_n    = !((xCounter >= H_SYNC_S) && (xCounter <= H_SYNC_E));
    ctl_next.vs_n    = !((yCounter >= V_SYNC_S) && (yCounter <= V_SYNC_E));
    ctl_next.frame   = (xCounter == 10'd0) && (yCounter == 10'd0);
    addr_full        = (({22'd0, yCounter}) >> RES_SHIFT) * FB_WIDTH
                     + (({22'd0, xCounter}) >> RES_SHIFT);
  end

  // Stage 1: address only advances on visible pixels, so it never leaves the framebuffer.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      ctl_s1      <= CTL_IDLE;
      fb.fb_addr  <= '0;
      fb.fb_rd_en <= 1'b0;
    end else begin
      ctl_s1      <= ctl_next;
      fb.fb_rd_en <= ctl_next.visible;
      if (ctl_next.visible) begin
        fb.fb_addr <= addr_full[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        ctl_dly[i] <= CTL_IDLE;
      end
    end else begin
      ctl_dly[0] <= ctl_s1;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        ctl_dly[i] <= ctl_dly[i-1];
      end
    end
  end

  assign ctl_mem = ctl_dly[MEM_LATENCY-1];
  assign pix_r   = fb.pixel_data[3*CB-1 -: CB];
  assign pix_g   = fb.pixel_data[2*CB-1 -: CB];
  assign pix_b   = fb.pixel_data[CB-1:0];

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_HS      <= ctl_mem.hs_n;
      VGA_VS      <= ctl_mem.vs_n;
      VGA_BLANK   <= ctl_mem.visible;
      frame_start <= ctl_mem.frame;
      if (ctl_mem.visible) begin
        VGA_R <= expand(pix_r);
        VGA_G <= expand(pix_g);
        VGA_B <= expand(pix_b);
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

  assign VGA_SYNC = 1'b1;

endmodule

// File: tb/tb_vga_sync_pixel_pipe.sv
// Directed bench for vga_sync_pixel_pipe: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=3 driven from the same counters, each with its own latency-matched memory.
module tb_vga_sync_pixel_pipe;

  logic       vga_clock = 1'b0;
  logic       resetn;
  logic [9:0] xCounter;
  logic [9:0] yCounter;

  logic [9:0] r1, g1, b1, r3, g3, b3;
  logic       hs1, vs1, blank1, sync1, frame1;
  logic       hs3, vs3, blank3, sync3, frame3;

  vga_sync_pixel_pipe_if #(.ADDR_WIDTH(17), .COLOR_CHANNEL_BITS(3)) fb1 ();
  vga_sync_pixel_pipe_if #(.ADDR_WIDTH(17), .COLOR_CHANNEL_BITS(3)) fb3 ();

  vga_sync_pixel_pipe #(.MEM_LATENCY(1)) dut1 (
    .vga_clock(vga_clock), .resetn(resetn), .xCounter(xCounter), .yCounter(yCounter),
    .fb(fb1.master), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
    .VGA_BLANK(blank1), .VGA_SYNC(sync1), .frame_start(frame1)
  );

  vga_sync_pixel_pipe #(.MEM_LATENCY(3)) dut3 (
    .vga_clock(vga_clock), .resetn(resetn), .xCounter(xCounter), .yCounter(yCounter),
    .fb(fb3.master), .VGA_R(r3), .VGA_G(g3), .VGA_B(b3), .VGA_HS(hs3), .VGA_VS(vs3),
    .VGA_BLANK(blank3), .VGA_SYNC(sync3), .frame_start(frame3)
  );

  // clock / reset
  always #20 vga_clock = ~vga_clock;

  // memory model: word = low 9 address bits, or a fixed word when mem_fixed_en
  logic       mem_fixed_en;
  logic [8:0] mem_fixed;
  logic [8:0] m1_q;
  logic [8:0] m3_q [3];

  function automatic logic [8:0] mem_word(input logic [16:0] a);
    return mem_fixed_en ? mem_fixed : a[8:0];
  endfunction

  always @(posedge vga_clock) begin
    m1_q    <= mem_word(fb1.fb_addr);
    m3_q[0] <= mem_word(fb3.fb_addr);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end

  assign fb1.pixel_data = m1_q;
  assign fb3.pixel_data = m3_q[2];

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic setxy(input int x, input int y);
    xCounter = 10'(x);
    yCounter = 10'(y);
  endtask

  int   hs1_low, hs1_first, hs1_last, blank1_hi, frame1_cnt, frame1_col;
  int   hs3_low, hs3_first, frame3_cnt;
  int   vs1_low, vs1_first;
  int   lat1, lat3;
  int   x1, x3, row;
  logic [7:0] f1v, b1v, f3v, b3v;
  logic [9:0] r3_at_frame;

  initial begin
    resetn       = 1'b0;
    mem_fixed_en = 1'b0;
    mem_fixed    = '0;
    setxy(100, 100);
    repeat (3) cyc();

    // reset state
    check("rst_fb_addr",  fb1.fb_addr, 0);
    check("rst_rd_en",    fb1.fb_rd_en, 0);
    check("rst_r",        r1, 0);
    check("rst_g",        g1, 0);
    check("rst_b",        b1, 0);
    check("rst_hs",       hs1, 1);
    check("rst_vs",       vs1, 1);
    check("rst_blank",    blank1, 0);
    check("rst_sync",     sync1, 1);
    check("rst_frame",    frame1, 0);
    check("rst_blank3",   blank3, 0);
    check("rst_hs3",      hs3, 1);

    // release with (100,100): addr = 50*320+50 = 16050, word 0x0B2
    resetn = 1'b1;
    cyc();
    check("rel_rd_en",    fb1.fb_rd_en, 1);
    check("rel_addr",     fb1.fb_addr, 16050);
    check("rel_blank_c1", blank1, 0);
    cyc();
    check("rel_blank_c2", blank1, 0);
    cyc();
    check("rel_blank_c3", blank1, 1);
    check("rel_blank3_c3", blank3, 0);
    check("rel_r_c3",     r1, 10'h124);
    check("rel_g_c3",     g1, 10'h36D);
    check("rel_b_c3",     b1, 10'h124);
    cyc();
    cyc();
    check("rel_blank3_c5", blank3, 1);

    // address sequence and latency alignment
    setxy(0, 0);     cyc();
    check("addr_0_0",  fb1.fb_addr, 0);
    check("frame_pre", frame1, 0);
    setxy(1, 0);     cyc();
    check("addr_1_0",  fb1.fb_addr, 0);
    setxy(2, 0);     cyc();
    check("addr_2_0",  fb1.fb_addr, 1);
    check("frame1_at", frame1, 1);
    check("frame3_early", frame3, 0);
    setxy(3, 0);     cyc();
    check("addr_3_0",  fb1.fb_addr, 1);
    check("frame1_post", frame1, 0);
    setxy(5, 3);     cyc();
    check("addr_5_3",  fb1.fb_addr, 322);
    check("frame3_at", frame3, 1);
    check("blank3_at_frame", blank3, 1);
    setxy(639, 479); cyc();
    check("addr_max",  fb1.fb_addr, 76799);
    check("frame3_post", frame3, 0);
    setxy(700, 10);  cyc();
    check("addr_hold", fb1.fb_addr, 76799);
    check("rd_en_blank", fb1.fb_rd_en, 0);
    check("r_5_3",     r1, 10'h2DB);
    check("g_5_3",     g1, 10'h000);
    check("b_5_3",     b1, 10'h124);
    cyc();
    check("r_max",     r1, 10'h3FF);
    check("b_max",     b1, 10'h3FF);
    check("blank_max", blank1, 1);
    check("hs_max",    hs1, 1);
    cyc();
    check("r_blanked", r1, 0);
    check("blank_700", blank1, 0);
    check("hs_700",    hs1, 0);
    check("vs_700",    vs1, 1);
    check("addr_hold2", fb1.fb_addr, 76799);
    check("r3_5_3",    r3, 10'h2DB);
    check("b3_5_3",    b3, 10'h124);
    cyc();
    check("g3_max",    g3, 10'h3FF);
    cyc();
    check("r3_blanked", r3, 0);
    check("blank3_700", blank3, 0);
    check("hs3_700",    hs3, 0);

    // fixed words through the colour expansion
    mem_fixed_en = 1'b1;
    mem_fixed    = 9'b101_010_111;
    setxy(100, 100);
    repeat (3) cyc();
    check("fix1_r",     r1, 10'b1011011011);
    check("fix1_g",     g1, 10'b0100100100);
    check("fix1_b",     b1, 10'h3FF);
    check("fix1_blank", blank1, 1);
    mem_fixed = 9'b011_100_001;
    repeat (2) cyc();
    check("fix2_r",     r1, 10'h1B6);
    check("fix2_g",     g1, 10'h249);
    check("fix2_b",     b1, 10'h092);

    // blanking region with all-ones data
    mem_fixed = 9'h1FF;
    setxy(700, 10);
    repeat (3) cyc();
    check("blk_r",      r1, 0);
    check("blk_g",      g1, 0);
    check("blk_b",      b1, 0);
    check("blk_blank",  blank1, 0);
    check("blk_rd_en",  fb1.fb_rd_en, 0);
    check("blk_addr",   fb1.fb_addr, 16050);

    // one full line on row 0
    hs1_low = 0; hs1_first = -1; hs1_last = -1; blank1_hi = 0; frame1_cnt = 0; frame1_col = -1;
    hs3_low = 0; hs3_first = -1; frame3_cnt = 0;
    for (int i = 0; i < 804; i++) begin
      setxy(i % 800, 0);
      cyc();
      x1 = i - 2;
      x3 = i - 4;
      if (x1 >= 0 && x1 < 800) begin
        if (!hs1) begin
          hs1_low++;
          if (hs1_first < 0) hs1_first = x1;
          hs1_last = x1;
        end
        if (blank1) blank1_hi++;
        if (frame1) begin
          frame1_cnt++;
          frame1_col = x1;
        end
      end
      if (x3 >= 0 && x3 < 800) begin
        if (!hs3) begin
          hs3_low++;
          if (hs3_first < 0) hs3_first = x3;
        end
        if (frame3) frame3_cnt++;
      end
    end
    check("line_hs_low",    hs1_low, 96);
    check("line_hs_first",  hs1_first, 659);
    check("line_hs_last",   hs1_last, 754);
    check("line_blank_hi",  blank1_hi, 640);
    check("line_frame_cnt", frame1_cnt, 1);
    check("line_frame_col", frame1_col, 0);
    check("line_hs3_low",   hs3_low, 96);
    check("line_hs3_first", hs3_first, 659);
    check("line_frame3_cnt", frame3_cnt, 1);

    // vertical sync rows
    vs1_low = 0; vs1_first = -1;
    for (int r = 0; r < 12; r++) begin
      setxy(700, 488 + r);
      cyc();
      row = 488 + r - 2;
      if (r >= 2 && !vs1) begin
        vs1_low++;
        if (vs1_first < 0) vs1_first = row;
      end
    end
    check("vs_low_rows", vs1_low, 2);
    check("vs_first_row", vs1_first, 493);

    // frame wrap (799,524) -> (0,0)
    mem_fixed = 9'b101_010_111;
    f1v = '0; b1v = '0; f3v = '0; b3v = '0; r3_at_frame = '0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: setxy(798, 524);
        1: setxy(799, 524);
        2: setxy(0, 0);
        3: setxy(1, 0);
        default: ;
      endcase
      cyc();
      f1v[i] = frame1;
      b1v[i] = blank1;
      f3v[i] = frame3;
      b3v[i] = blank3;
      if (frame3) r3_at_frame = r3;
    end
    check("wrap_frame1", f1v, 8'b0001_0000);
    check("wrap_blank1", b1v, 8'b1111_0000);
    check("wrap_frame3", f3v, 8'b0100_0000);
    check("wrap_blank3", b3v, 8'b1100_0000);
    check("wrap_r3",     r3_at_frame, 10'h2DB);

    // asynchronous reset mid-frame, then refill
    resetn = 1'b0;
    #1;
    check("mid_blank",  blank1, 0);
    check("mid_hs",     hs1, 1);
    check("mid_addr",   fb1.fb_addr, 0);
    check("mid_rd_en",  fb1.fb_rd_en, 0);
    check("mid_r",      r1, 0);
    check("mid_blank3", blank3, 0);
    cyc();
    resetn = 1'b1;
    lat1 = 0; lat3 = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (blank1 && lat1 == 0) lat1 = k;
      if (blank3 && lat3 == 0) lat3 = k;
    end
    check("refill_lat1", lat1, 3);
    check("refill_lat3", lat3, 5);
    check("refill_r1",   r1, 10'h2DB);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
